// File: rtl/game_pkg.sv
// Shared constants, scene codes and gap packing helpers for the flappy-bird sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    localparam int HEIGHT = 40;
    localparam int WIDTH  = 64;

    typedef enum logic [1:0] {
        SCENE_SPLASH   = 2'd0,
        SCENE_PLAYING  = 2'd1,
        SCENE_GAMEOVER = 2'd2
    } scene_t;

    localparam logic [7:0] KEY_SPACE   = 8'd32;
    localparam logic [7:0] KEY_QUIT    = 8'd120;
    localparam logic [7:0] KEY_RESTART = 8'd114;

    // Field MSBs inside one 24-bit gap word {pos, max_bnd, min_bnd}
    localparam int POS_MSB = 23;
    localparam int MAX_MSB = 15;
    localparam int MIN_MSB = 7;

    // gap1 (20,30,20), gap2 (40,25,15), gap3 (60,35,25); gap1 in the top 24 bits
    localparam logic [71:0] GAPS_INIT = {8'd20, 8'd30, 8'd20,
                                         8'd40, 8'd25, 8'd15,
                                         8'd60, 8'd35, 8'd25};

    localparam logic [7:0] ALT_INIT  = 8'd20;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Extract one 8-bit field of gap idx (0 = gap1) from a packed 72-bit gap bus
    function automatic logic [7:0] gap_field(input logic [71:0] g, input int idx, input int msb);
        return 8'(g >> ((2 - idx) * 24 + msb - 7));
    endfunction

endpackage

// File: rtl/game_sequencer_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to randomise respawned gap bounds.
// Latency: advances one step every clock; seeded on reset only.
// Backpressure: none, free-running.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    // Shift left, feeding back the parity of the polynomial taps
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Flappy-bird game state: scene FSM, bird physics, gap scrolling/respawn, collision, score.
// Latency: every output is registered; a key sampled on one edge takes effect on that edge.
// Backpressure: none; inp is sampled every clock and outputs are always valid.
module game_sequencer
    import game_pkg::*;
#(
    parameter int HEIGHT      = game_pkg::HEIGHT,
    parameter int TICK_DIV    = 4,
    parameter int FLAP_CYCLES = 5,
    parameter int FLAP_RISE   = 2,
    parameter int GAP_SIZE    = 10,
    parameter int RESPAWN_POS = 60,
    parameter int BIRD_COL    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  inp,
    output logic [1:0]  scene,
    output logic [8:0]  bird,
    output logic [71:0] gaps,
    output logic [7:0]  score
);

    localparam int              TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]      ALT_MAX   = 8'(HEIGHT - 1);
    localparam logic [7:0]      RISE8     = 8'(FLAP_RISE);
    localparam logic [7:0]      FLAP_LOAD = 8'(FLAP_CYCLES);
    localparam logic [7:0]      RESPAWN8  = 8'(RESPAWN_POS);
    localparam logic [7:0]      GAP8      = 8'(GAP_SIZE);
    localparam logic [7:0]      COL8      = 8'(BIRD_COL);
    // Pipes are wide: a gap is "at the bird" for the 7 columns ahead of it too
    localparam logic [7:0]      ZONE8     = 8'(BIRD_COL + 6);

    scene_t          scene_q;
    logic [7:0]      alt_q;
    logic            flapping_q;
    logic [7:0]      flap_cnt_q;
    logic            pending_q;
    logic [7:0]      score_q;
    logic [TW-1:0]   tick_cnt_q;
    logic [7:0]      pos_q [3];
    logic [7:0]      max_q [3];
    logic [7:0]      min_q [3];
    logic [7:0]      lfsr_q;

    logic            is_play;
    logic            tick;
    logic            space;
    logic            quit;
    logic            restart;
    logic            flap_now;
    logic            pipe_hit;
    logic            collide;
    logic            pass_col;
    logic [8:0]      alt_sum;
    logic [7:0]      alt_rise;
    logic [7:0]      alt_fall;
    logic [7:0]      flap_cnt_nxt;
    logic [7:0]      resp_min [3];

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign is_play  = (scene_q == SCENE_PLAYING);
    assign tick     = is_play && (tick_cnt_q == TICK_LAST);
    assign space    = (inp == KEY_SPACE);
    assign quit     = (inp == KEY_QUIT);
    assign restart  = (scene_q == SCENE_GAMEOVER) && (inp == KEY_RESTART);
    // A space landing on the tick clock is consumed by that tick directly
    assign flap_now = pending_q || space;
    assign collide  = (alt_q == 8'd0) || pipe_hit;

    assign alt_sum      = {1'b0, alt_q} + {1'b0, RISE8};
    assign alt_rise     = (alt_sum > {1'b0, ALT_MAX}) ? ALT_MAX : alt_sum[7:0];
    assign alt_fall     = (alt_q == 8'd0) ? 8'd0 : alt_q - 8'd1;
    assign flap_cnt_nxt = space ? FLAP_LOAD :
                          (flap_cnt_q != 8'd0) ? flap_cnt_q - 8'd1 : 8'd0;

    // Per-gap pipe collision, score column detection and respawn bounds from the LFSR
    always_comb begin
        pipe_hit = 1'b0;
        pass_col = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((pos_q[i] <= ZONE8) && ((alt_q <= min_q[i]) || (alt_q >= max_q[i]))) begin
                pipe_hit = 1'b1;
            end
            if (pos_q[i] == COL8) begin
                pass_col = 1'b1;
            end
            resp_min[i] = 8'd4 + {4'd0, 4'(lfsr_q >> i)};
        end
    end

    // Scene FSM plus all game state; reset and restart both reload the init values
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            scene_q    <= SCENE_SPLASH;
            alt_q      <= ALT_INIT;
            flapping_q <= 1'b0;
            flap_cnt_q <= 8'd0;
            pending_q  <= 1'b0;
            score_q    <= 8'd0;
            tick_cnt_q <= '0;
            for (int i = 0; i < 3; i++) begin
                pos_q[i] <= gap_field(GAPS_INIT, i, POS_MSB);
                max_q[i] <= gap_field(GAPS_INIT, i, MAX_MSB);
                min_q[i] <= gap_field(GAPS_INIT, i, MIN_MSB);
            end
        end else begin
            unique case (scene_q)
                SCENE_SPLASH: begin
                    // The starting space only changes scene, it never arms a flap
                    if (space) begin
                        scene_q    <= SCENE_PLAYING;
                        tick_cnt_q <= '0;
                    end
                end
                SCENE_PLAYING: begin
                    if (collide || quit) begin
                        scene_q <= SCENE_GAMEOVER;
                    end
                    flap_cnt_q <= flap_cnt_nxt;
                    flapping_q <= (flap_cnt_nxt != 8'd0);
                    if (tick) begin
                        tick_cnt_q <= '0;
                        pending_q  <= 1'b0;
                        alt_q      <= flap_now ? alt_rise : alt_fall;
                        if (pass_col && (score_q != 8'hFF)) begin
                            score_q <= score_q + 8'd1;
                        end
                        for (int i = 0; i < 3; i++) begin
                            if (pos_q[i] == 8'd0) begin
                                pos_q[i] <= RESPAWN8;
                                min_q[i] <= resp_min[i];
                                max_q[i] <= resp_min[i] + GAP8;
                            end else begin
                                pos_q[i] <= pos_q[i] - 8'd1;
                            end
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TW'(1);
                        pending_q  <= flap_now;
                    end
                end
                SCENE_GAMEOVER: begin
                    // Everything visible freezes; only the hidden countdown is dropped
                    flap_cnt_q <= 8'd0;
                end
                default: begin
                    scene_q <= SCENE_SPLASH;
                end
            endcase
        end
    end

    assign scene = scene_q;
    assign bird  = {alt_q, flapping_q};
    assign score = score_q;
    assign gaps  = {pos_q[0], max_q[0], min_q[0],
                    pos_q[1], max_q[1], min_q[1],
                    pos_q[2], max_q[2], min_q[2]};

endmodule

// File: tb/tb_game_sequencer.sv
// Directed + randomised bench for game_sequencer against a rule-level game model.
// Latency: inputs driven on the falling edge, outputs compared 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_game_sequencer;

    localparam int TICK_DIV = 4;
    localparam logic [71:0] INIT_GAPS = 72'h14_1E_14_28_19_0F_3C_23_19;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  inp = 8'd0;
    logic [1:0]  scene;
    logic [8:0]  bird;
    logic [71:0] gaps;
    logic [7:0]  score;

    int checks = 0;
    int errors = 0;

    // Game model: plain integers following the rules of the game
    int m_scene, m_alt, m_flap, m_cd, m_pend, m_score, m_phase, m_lfsr, m_ticks;
    int m_pos [3];
    int m_min [3];
    int m_max [3];

    game_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .inp   (inp),
        .scene (scene),
        .bird  (bird),
        .gaps  (gaps),
        .score (score)
    );

    always #5 clk = ~clk;

    task automatic model_init();
        m_scene = 0; m_alt = 20; m_flap = 0; m_cd = 0; m_pend = 0;
        m_score = 0; m_phase = 0; m_ticks = 0;
        m_pos = '{20, 40, 60};
        m_max = '{30, 25, 35};
        m_min = '{20, 15, 25};
    endtask

    function automatic logic [71:0] model_gaps();
        return {8'(m_pos[0]), 8'(m_max[0]), 8'(m_min[0]),
                8'(m_pos[1]), 8'(m_max[1]), 8'(m_min[1]),
                8'(m_pos[2]), 8'(m_max[2]), 8'(m_min[2])};
    endfunction

    task automatic model_step(input int key, input bit r);
        int  fb;
        bit  hit, is_tick, passed;
        if (r) begin
            model_init();
            m_lfsr = 8'hA5;
            return;
        end
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        if (m_scene == 2 && key == 114) begin
            model_init();
        end else if (m_scene == 0) begin
            if (key == 32) begin
                m_scene = 1;
                m_phase = 0;
            end
        end else if (m_scene == 1) begin
            hit = (m_alt == 0);
            passed = 0;
            for (int i = 0; i < 3; i++) begin
                if (m_pos[i] <= 8 && (m_alt <= m_min[i] || m_alt >= m_max[i])) hit = 1;
                if (m_pos[i] == 2) passed = 1;
            end
            is_tick = (m_phase == TICK_DIV - 1);
            if (key == 32) m_cd = 5;
            else if (m_cd > 0) m_cd--;
            m_flap = (m_cd > 0);
            if (is_tick) begin
                if (m_pend || key == 32) m_alt = (m_alt + 2 > 39) ? 39 : m_alt + 2;
                else if (m_alt > 0) m_alt--;
                m_pend = 0;
                if (passed && m_score < 255) m_score++;
                for (int i = 0; i < 3; i++) begin
                    if (m_pos[i] == 0) begin
                        m_pos[i] = 60;
                        m_min[i] = 4 + ((m_lfsr >> i) & 15);
                        m_max[i] = m_min[i] + 10;
                    end else begin
                        m_pos[i]--;
                    end
                end
                m_phase = 0;
                m_ticks++;
            end else begin
                m_pend = m_pend | (key == 32);
                m_phase++;
            end
            if (hit || key == 120) m_scene = 2;
        end else begin
            m_cd = 0;
        end
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
    endtask

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] key, input logic r);
        @(negedge clk);
        inp = key;
        rst = r;
        @(posedge clk);
        model_step(int'(key), r);
        #1;
        chk("scene", 72'(scene), 72'(m_scene));
        chk("bird",  72'(bird),  72'({8'(m_alt), 1'(m_flap)}));
        chk("gaps",  gaps,       model_gaps());
        chk("score", 72'(score), 72'(m_score));
    endtask

    task automatic chk_init(input string tag);
        chk({tag, "_scene"}, 72'(scene), 72'd0);
        chk({tag, "_bird"},  72'(bird),  72'h028);
        chk({tag, "_gaps"},  gaps,       INIT_GAPS);
        chk({tag, "_score"}, 72'(score), 72'd0);
    endtask

    initial begin
        int hi, maxalt, tgt, mid, saved_lfsr, n, sel, k;
        logic [7:0] key;

        model_init();
        m_lfsr = 8'hA5;
        step(8'd0, 1'b1);
        step(8'd0, 1'b1);
        chk_init("reset");

        // Start: scene changes next clock, no flap armed
        step(8'd32, 1'b0);
        chk("start_scene", 72'(scene), 72'd1);
        chk("start_noflap", 72'(bird[0]), 72'd0);

        // Free fall into gap1's lower pipe
        for (int j = 1; j <= 48; j++) begin
            step(8'd0, 1'b0);
            if (j == 4) begin
                chk("fall_alt19", 72'(bird[8:1]), 72'd19);
                chk("fall_pos1",  72'(gaps[71:64]), 72'd19);
                chk("fall_pos2",  72'(gaps[47:40]), 72'd39);
                chk("fall_pos3",  72'(gaps[23:16]), 72'd59);
            end
        end
        chk("t12_alt", 72'(bird[8:1]), 72'd8);
        chk("t12_pos1", 72'(gaps[71:64]), 72'd8);
        chk("t12_scene", 72'(scene), 72'd1);
        step(8'd0, 1'b0);
        chk("collide_scene", 72'(scene), 72'd2);

        // Restart, then a single flap
        step(8'd114, 1'b0);
        chk_init("restart1");
        step(8'd32, 1'b0);
        hi = 0;
        for (int j = 1; j <= 10; j++) begin
            step((j == 1) ? 8'd32 : 8'd0, 1'b0);
            if (bird[0]) hi++;
            if (j == 4) chk("flap_rise", 72'(bird[8:1]), 72'd22);
            if (j == 8) chk("flap_fall", 72'(bird[8:1]), 72'd21);
        end
        chk("flap_len", 72'(hi), 72'd5);

        // Flap every tick to hit the ceiling
        step(8'd120, 1'b0);
        chk("quit_scene", 72'(scene), 72'd2);
        step(8'd114, 1'b0);
        step(8'd32, 1'b0);
        maxalt = 0;
        for (int j = 1; j <= 44; j++) begin
            step((j % 4 == 1) ? 8'd32 : 8'd0, 1'b0);
            if (int'(bird[8:1]) > maxalt) maxalt = int'(bird[8:1]);
        end
        chk("ceiling_alt", 72'(bird[8:1]), 72'd39);
        chk("ceiling_max", 72'(maxalt), 72'd39);
        step(8'd120, 1'b0);

        // Autopilot through three gaps until gap3 respawns
        step(8'd114, 1'b0);
        step(8'd32, 1'b0);
        saved_lfsr = 0;
        n = 0;
        while (m_ticks < 61 && m_scene == 1 && n < 400) begin
            tgt = 0;
            for (int i = 1; i < 3; i++) if (m_pos[i] < m_pos[tgt]) tgt = i;
            mid = (m_min[tgt] + m_max[tgt]) / 2;
            key = (m_phase == TICK_DIV - 1 && m_alt < mid) ? 8'd32 : 8'd0;
            if (m_phase == TICK_DIV - 1 && m_ticks == 60) saved_lfsr = m_lfsr;
            step(key, 1'b0);
            n++;
        end
        k = 4 + ((saved_lfsr >> 2) & 15);
        chk("ap_alive", 72'(scene), 72'd1);
        chk("ap_score", 72'(score), 72'd3);
        chk("resp_pos3", 72'(gaps[23:16]), 72'd60);
        chk("resp_min3", 72'(gaps[7:0]), 72'(k));
        chk("resp_max3", 72'(gaps[15:8]), 72'(k + 10));
        step(8'd120, 1'b0);
        chk("ap_quit", 72'(scene), 72'd2);
        step(8'd114, 1'b0);
        chk_init("restart2");

        // Random keys with occasional synchronous reset
        for (int j = 0; j < 1500; j++) begin
            sel = $urandom_range(0, 99);
            if (sel < 55)      key = 8'd0;
            else if (sel < 75) key = 8'd32;
            else if (sel < 80) key = 8'd120;
            else if (sel < 85) key = 8'd114;
            else               key = 8'($urandom_range(0, 255));
            step(key, ($urandom_range(0, 199) == 0));
        end

        // Reset in the middle of play
        step(8'd32, 1'b0);
        step(8'd32, 1'b0);
        step(8'd0, 1'b0);
        step(8'd0, 1'b1);
        chk_init("midreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
